// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
//   EX/MEM pipeline boundary register of the 5-stage CPU. It latches the EX
//   results and control fields for the MEM stage. It also holds the
//   architectural condition-flag register (zr/neg/ov) that the MEM-stage
//   branch resolver reads.
//
//   Supported operations:
//     - stall: hold the stage contents.
//     - flush: insert a bubble when a branch is taken.
//     - WB->MEM store-data forwarding, both on load and while the stage
//       is held by a stall.
//
// Ports
//   clk          rising-edge clock for every state update
//   rst          synchronous active-high reset
//   stall        hold all stage contents
//   flush        load a bubble instead of the EX instruction
//   ex_valid     EX holds a real instruction
//   M_in         [0]=MemRead [1]=MemWrite [2]=branch
//   WB_in        writeback control (passed through)
//   dst_in       destination register
//   st_src_in    store-data source register
//   ALU_in       ALU result / memory address
//   wdata_in     store data as read in EX
//   PCbranch_in  branch target
//   bcond_in     branch condition code
//   flags_in     ALU flags [0]=zr [1]=neg [2]=ov
//   flag_we      per-flag write enables (same bit order)
//   wb_we/wb_dst/wb_data  WB-stage register write port
//   valid, M, WB, dst, bcond, ALU, addr, wdata, PCbranch  registered outputs
//   flags        flag register contents
module ex_mem_pipe #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [2:0]    M_in,
  input  logic [1:0]    WB_in,
  input  logic [RW-1:0] dst_in,
  input  logic [RW-1:0] st_src_in,
  input  logic [DW-1:0] ALU_in,
  input  logic [DW-1:0] wdata_in,
  input  logic [DW-1:0] PCbranch_in,
  input  logic [2:0]    bcond_in,
  input  logic [2:0]    flags_in,
  input  logic [2:0]    flag_we,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic          valid,
  output logic [2:0]    M,
  output logic [1:0]    WB,
  output logic [RW-1:0] dst,
  output logic [2:0]    bcond,
  output logic [DW-1:0] ALU,
  output logic [DW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] PCbranch,
  output logic [2:0]    flags
);

  logic          valid_reg;
  logic [2:0]    m_reg;
  logic [1:0]    wb_reg;
  logic [RW-1:0] dst_reg;
  logic [RW-1:0] st_src_reg;
  logic [2:0]    bcond_reg;
  logic [DW-1:0] alu_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] pcbranch_reg;
  logic [2:0]    flags_reg;
  logic [2:0]    flags_next;

  logic load_en;
  logic fwd_load;
  logic fwd_hold;

  // A load edge captures the EX instruction. flush wins over stall.
  assign load_en = !flush && !stall;

  // Forward WB write data into an incoming store. R0 is never forwarded
  // because it is hardwired to zero.
  assign fwd_load = M_in[1] && wb_we && (wb_dst == st_src_in) &&
                    (wb_dst != '0);

  // A store held by a stall keeps picking up WB results for its source
  // register, so its data is current when the stall releases.
  assign fwd_hold = m_reg[1] && wb_we && (wb_dst == st_src_reg) &&
                    (wb_dst != '0);

  // Each flag bit is written independently, and only by a real instruction
  // on a load edge. Branches carry flag_we=0 and leave the flags intact.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_flag
      assign flags_next[gi] = (load_en && ex_valid && flag_we[gi]) ?
                              flags_in[gi] : flags_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      m_reg        <= '0;
      wb_reg       <= '0;
      dst_reg      <= '0;
      st_src_reg   <= '0;
      bcond_reg    <= '0;
      alu_reg      <= '0;
      wdata_reg    <= '0;
      pcbranch_reg <= '0;
      flags_reg    <= '0;
    end else if (flush) begin
      // Bubble: the data fields are zeroed and the flags hold.
      valid_reg    <= 1'b0;
      m_reg        <= '0;
      wb_reg       <= '0;
      dst_reg      <= '0;
      st_src_reg   <= '0;
      bcond_reg    <= '0;
      alu_reg      <= '0;
      wdata_reg    <= '0;
      pcbranch_reg <= '0;
    end else if (stall) begin
      if (fwd_hold) begin
        wdata_reg <= wb_data;
      end
    end else begin
      valid_reg    <= ex_valid;
      // Control for a non-instruction must not cause side effects downstream.
      m_reg        <= ex_valid ? M_in : 3'b000;
      wb_reg       <= ex_valid ? WB_in : 2'b00;
      dst_reg      <= dst_in;
      st_src_reg   <= st_src_in;
      bcond_reg    <= bcond_in;
      alu_reg      <= ALU_in;
      wdata_reg    <= fwd_load ? wb_data : wdata_in;
      pcbranch_reg <= PCbranch_in;
      flags_reg    <= flags_next;
    end
  end

  assign valid    = valid_reg;
  assign M        = m_reg;
  assign WB       = wb_reg;
  assign dst      = dst_reg;
  assign bcond    = bcond_reg;
  assign ALU      = alu_reg;
  assign addr     = alu_reg;
  assign wdata    = wdata_reg;
  assign PCbranch = pcbranch_reg;
  assign flags    = flags_reg;

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

EX/MEM pipeline boundary of the 5-stage CPU. Captures the EX-stage results and control fields, and presents them to the MEM stage. It also owns the architectural condition-flag register (zr/neg/ov) that the MEM-stage branch resolver reads. It supports stall (hold), flush (bubble insertion on a taken branch), and WB→MEM forwarding of store data.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 4, register-specifier width (R0 hardwired zero)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage contents (from hazard unit)
- flush  in  1  replace the incoming instruction with a bubble (taken branch)
- ex_valid  in  1  EX holds a real instruction
- M_in  in  3  [0]=MemRead, [1]=MemWrite, [2]=branch
- WB_in  in  2  writeback control, passed through
- dst_in  in  RW  destination register
- st_src_in  in  RW  store-data source register
- ALU_in  in  DW  ALU result / memory address
- wdata_in  in  DW  store data as read in EX
- PCbranch_in  in  DW  branch target
- bcond_in  in  3  branch condition code
- flags_in  in  3  [0]=zr, [1]=neg, [2]=ov from ALU
- flag_we  in  3  per-flag write enables, same bit order
- wb_we, wb_dst, wb_data  in  1/RW/DW  WB-stage register write
- valid  out  1  MEM holds a real instruction
- M, WB, dst, bcond  out  3/2/RW/3  registered control
- ALU, addr  out  DW  registered ALU result (addr identical to ALU)
- wdata  out  DW  registered, forwarded store data
- PCbranch  out  DW  registered branch target
- flags  out  3  flag register contents

## Operation
- Reset: every output and internal register is 0. valid=0, M=0, WB=0, flags=3'b000.
- Load: the edge loads when stall=0 and flush=0.
  - valid←ex_valid.
  - All fields ←inputs.
  - M and WB are forced to 0 if ex_valid=0.
- Flush: if flush=1, the edge loads a bubble regardless of stall. Bubble: valid=0, M=0, WB=0, flags unchanged. Data fields are don't-care but are zeroed.
- Stall: if stall=1 and flush=0, all pipeline fields hold. The flag register holds.
- Flag register:
  - Each bit i updates to flags_in[i] on a load edge when ex_valid=1 and flag_we[i]=1.
  - It is never updated on stall, flush, or bubble edges.
  - Branches carry flag_we=0, so a branch in MEM sees flags from the youngest older flag-setting instruction.
- Store-data forwarding on a load edge:
  - Condition: M_in[1]=1, wb_we=1, wb_dst==st_src_in, and wb_dst≠0.
  - If met: wdata←wb_data. Otherwise wdata←wdata_in.
- Forwarding while stalled:
  - Condition: stall=1, M[1]=1, wb_we=1, wb_dst==held st_src, wb_dst≠0.
  - If met: wdata←wb_data.
  - This keeps store data current across multi-cycle stalls.
- No arithmetic is performed. All widths pass through unchanged.

## Timing
- Latency: 1 cycle EX→MEM. Outputs are purely registered, with no combinational input→output paths.
- flags output reflects updates from the same edge that loads the instruction.
- Priority at each edge: rst > flush > stall > load.
- Simultaneous flush and stall: bubble is inserted and flags hold.
- Reset asserted mid-stall or mid-flush: all state clears on that edge. The first load follows on the edge after rst deasserts.
- A forwarding match with wb_dst=0 never forwards.

## Test plan
- Reset: hold rst 2 cycles with arbitrary inputs → all outputs 0, valid=0.
- Load and flags:
  - Stimulus: ex_valid=1, ALU_in=16'h1234, M_in=3'b001, flags_in=3'b010, flag_we=3'b111.
  - Required, one edge later: ALU=addr=16'h1234, M=3'b001, valid=1, flags=3'b010.
  - Then load a branch with flag_we=0 → flags stay 3'b010.
- Stall:
  - Load ALU_in=16'hAAAA, then assert stall for 3 cycles while driving ALU_in=16'h5555 and flag_we=3'b111 → ALU stays 16'hAAAA and flags hold.
  - Deassert stall → next edge gives ALU=16'h5555.
- Flush vs stall: stall=1, flush=1, ex_valid=1, M_in=3'b010 → next edge gives valid=0, M=0, WB=0, flags unchanged.
- Store forwarding:
  - Stimulus: M_in=3'b010, st_src_in=4'd3, wdata_in=16'h0001, wb_we=1, wb_dst=4'd3, wb_data=16'hBEEF → wdata=16'hBEEF.
  - Same with wb_dst=4'd0 and st_src_in=4'd0 → wdata=16'h0001.
- Stalled-store forwarding:
  - Store held with st_src=4'd5 and stall=1.
  - Drive wb_we=1, wb_dst=4'd5, wb_data=16'h00C0 for one cycle → wdata=16'h00C0 and remains after stall is released.
